// File: rtl/count_checker.sv
// Consumer-side sequence checker for a free-running up-counter bus.
// Locks on a run of +1 increments, then reports skips, repeats and counter resets.
module count_checker #(
  parameter int WIDTH    = 3,
  parameter int LOCK_CNT = 4,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             res,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_count,
  input  logic             clr_err,
  output logic             locked,
  output logic             err_pulse,
  output logic             rst_seen,
  output logic [ERR_W-1:0] err_count,
  output logic [WIDTH-1:0] expected
);

  typedef enum logic [1:0] {
    IDLE,
    ACQUIRE,
    LOCKED
  } state_t;

  state_t           r_state, w_state_n;
  logic [WIDTH-1:0] r_prev, w_prev_n;
  logic [7:0]       r_run, w_run_n;
  logic [ERR_W-1:0] r_err, w_err_n;
  logic             r_epl, w_epl_n;
  logic             r_rpl, w_rpl_n;
  logic [WIDTH-1:0] r_exp, w_exp_n;
  logic [WIDTH-1:0] w_inc;
  logic [7:0]       w_run_inc;
  logic             w_good;
  logic             w_hit;

  // Sized wire keeps the +1 truncated so the top value wraps to zero.
  assign w_inc     = r_prev + WIDTH'(1);
  assign w_good    = (in_count == w_inc);
  assign w_run_inc = r_run + 8'd1;

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_state <= IDLE;
      r_prev  <= '0;
      r_run   <= '0;
      r_err   <= '0;
      r_epl   <= 1'b0;
      r_rpl   <= 1'b0;
      r_exp   <= '0;
    end else begin
      r_state <= w_state_n;
      r_prev  <= w_prev_n;
      r_run   <= w_run_n;
      r_err   <= w_err_n;
      r_epl   <= w_epl_n;
      r_rpl   <= w_rpl_n;
      r_exp   <= w_exp_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_prev_n  = r_prev;
    w_run_n   = r_run;
    w_epl_n   = 1'b0;
    w_rpl_n   = 1'b0;
    w_hit     = 1'b0;
    if (in_valid) begin
      unique case (r_state)
        IDLE: begin
          w_prev_n  = in_count;
          w_run_n   = '0;
          w_state_n = ACQUIRE;
        end
        ACQUIRE: begin
          w_prev_n = in_count;
          if (!w_good) begin
            w_run_n = '0;
          end else if (w_run_inc == 8'(LOCK_CNT)) begin
            w_run_n   = '0;
            w_state_n = LOCKED;
          end else begin
            w_run_n = w_run_inc;
          end
        end
        LOCKED: begin
          w_prev_n = in_count;
          if (!w_good) begin
            w_run_n   = '0;
            w_state_n = ACQUIRE;
            // A return to zero is the counter restarting, not a fault.
            if (in_count == '0) begin
              w_rpl_n = 1'b1;
            end else begin
              w_epl_n = 1'b1;
              w_hit   = 1'b1;
            end
          end
        end
        default: w_state_n = IDLE;
      endcase
    end
  end

  always_comb begin
    w_err_n = r_err;
    if (clr_err) begin
      w_err_n = w_hit ? ERR_W'(1) : '0;
    end else if (w_hit && (r_err != '1)) begin
      w_err_n = r_err + ERR_W'(1);
    end
  end

  always_comb begin
    w_exp_n = '0;
    if (w_state_n != IDLE) begin
      w_exp_n = w_prev_n + WIDTH'(1);
    end
  end

  assign locked    = (r_state == LOCKED);
  assign err_pulse = r_epl;
  assign rst_seen  = r_rpl;
  assign err_count = r_err;
  assign expected  = r_exp;

endmodule

// File: tb/tb_count_checker.sv
// Bench for count_checker: directed scenarios plus a random stream,
// all checked against a streak-based reference model.
module tb_count_checker;

  localparam int WIDTH    = 3;
  localparam int LOCK_CNT = 4;
  localparam int ERR_W    = 2;
  localparam int MODV     = 1 << WIDTH;
  localparam int EMAX     = (1 << ERR_W) - 1;

  logic             clk = 1'b0;
  logic             res = 1'b0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_count = '0;
  logic             clr_err = 1'b0;
  logic             locked;
  logic             err_pulse;
  logic             rst_seen;
  logic [ERR_W-1:0] err_count;
  logic [WIDTH-1:0] expected;

  count_checker #(
    .WIDTH(WIDTH), .LOCK_CNT(LOCK_CNT), .ERR_W(ERR_W)
  ) dut (
    .clk(clk), .res(res), .in_valid(in_valid),
    .in_count(in_count), .clr_err(clr_err),
    .locked(locked), .err_pulse(err_pulse),
    .rst_seen(rst_seen), .err_count(err_count),
    .expected(expected)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model: locked means the current run of +1 steps since the
  // last capture or break has reached LOCK_CNT.
  bit m_have;
  int m_prev;
  int m_streak;
  int m_errs;
  bit m_pe;
  bit m_pr;

  function automatic logic [7:0] dut_vec();
    return {locked, err_pulse, rst_seen, err_count, expected};
  endfunction

  function automatic logic [7:0] mdl_vec();
    logic       l;
    logic [2:0] e;
    logic [1:0] c;
    l = m_have && (m_streak >= LOCK_CNT);
    e = m_have ? 3'((m_prev + 1) % MODV) : 3'd0;
    c = 2'(m_errs);
    return {l, m_pe, m_pr, c, e};
  endfunction

  task automatic model_reset();
    m_have = 0; m_prev = 0; m_streak = 0;
    m_errs = 0; m_pe = 0; m_pr = 0;
  endtask

  task automatic model_step(input bit v, input int c, input bit clr);
    bit was_locked;
    bit err;
    err = 0; m_pe = 0; m_pr = 0;
    if (v) begin
      if (!m_have) begin
        m_have = 1; m_streak = 0;
      end else if (c == (m_prev + 1) % MODV) begin
        m_streak++;
      end else begin
        was_locked = (m_streak >= LOCK_CNT);
        if (was_locked && c == 0) m_pr = 1;
        if (was_locked && c != 0) begin
          m_pe = 1; err = 1;
        end
        m_streak = 0;
      end
      m_prev = c;
    end
    if (clr) m_errs = err ? 1 : 0;
    else if (err && m_errs < EMAX) m_errs++;
  endtask

  task automatic step(input bit v, input int c, input bit clr);
    @(negedge clk);
    in_valid = v;
    in_count = 3'(c);
    clr_err  = clr;
    @(posedge clk);
    #1;
    model_step(v, c, clr);
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 0; clr_err = 0;
    res = 0;
    #1;
    model_reset();
    @(negedge clk);
    res = 1;
  endtask

  task automatic lock_from(input int s);
    for (int i = 0; i < LOCK_CNT + 1; i++) step(1, (s + i) % MODV, 0);
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if (dut_vec() !== 8'h00) begin
      fails++;
      $display("FAIL reset: got %b want %b", dut_vec(), 8'h00);
    end
  endtask

  task automatic test_lock_wrap();
    int seq[10] = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1};
    do_reset();
    foreach (seq[i]) begin
      step(1, seq[i], 0);
      tests++;
      if (dut_vec() !== mdl_vec()) begin
        fails++;
        $display("FAIL lock_wrap[%0d]: got %b want %b",
                 i, dut_vec(), mdl_vec());
      end
      if (i >= 4) begin
        tests++;
        if (locked !== 1'b1 || err_pulse !== 1'b0) begin
          fails++;
          $display("FAIL lock_hold[%0d]: got l=%b e=%b want l=1 e=0",
                   i, locked, err_pulse);
        end
      end
    end
    tests++;
    if (expected !== 3'd2) begin
      fails++;
      $display("FAIL wrap_expected: got %0d want 2", expected);
    end
  endtask

  task automatic test_skip();
    do_reset();
    lock_from(1);
    step(1, 3, 0);
    tests++;
    if ({err_pulse, err_count, locked, expected} !== {1'b1, 2'd1, 1'b0, 3'd4}) begin
      fails++;
      $display("FAIL skip: got e=%b c=%0d l=%b x=%0d want e=1 c=1 l=0 x=4",
               err_pulse, err_count, locked, expected);
    end
    step(1, 4, 0);
    tests++;
    if (err_pulse !== 1'b0) begin
      fails++;
      $display("FAIL skip_pulse_width: got %b want 0", err_pulse);
    end
    for (int i = 5; i <= 7; i++) begin
      step(1, i, 0);
      tests++;
      if (dut_vec() !== mdl_vec()) begin
        fails++;
        $display("FAIL skip_relock[%0d]: got %b want %b",
                 i, dut_vec(), mdl_vec());
      end
    end
    tests++;
    if (locked !== 1'b1) begin
      fails++;
      $display("FAIL skip_relocked: got %b want 1", locked);
    end
  endtask

  task automatic test_counter_reset();
    do_reset();
    lock_from(1);
    step(1, 0, 0);
    tests++;
    if ({rst_seen, err_pulse, err_count, locked} !== {1'b1, 1'b0, 2'd0, 1'b0}) begin
      fails++;
      $display("FAIL cnt_reset: got r=%b e=%b c=%0d l=%b want r=1 e=0 c=0 l=0",
               rst_seen, err_pulse, err_count, locked);
    end
    for (int i = 1; i <= 4; i++) begin
      step(1, i, 0);
      tests++;
      if (dut_vec() !== mdl_vec()) begin
        fails++;
        $display("FAIL cnt_reset_relock[%0d]: got %b want %b",
                 i, dut_vec(), mdl_vec());
      end
    end
    tests++;
    if (locked !== 1'b1 || rst_seen !== 1'b0) begin
      fails++;
      $display("FAIL cnt_reset_locked: got l=%b r=%b want l=1 r=0",
               locked, rst_seen);
    end
  endtask

  task automatic test_gaps();
    logic [7:0] held;
    do_reset();
    lock_from(6);
    held = dut_vec();
    for (int i = 0; i < 10; i++) begin
      step(0, 6, 0);
      tests++;
      if (dut_vec() !== mdl_vec() || dut_vec() !== held) begin
        fails++;
        $display("FAIL gap_hold[%0d]: got %b want %b",
                 i, dut_vec(), mdl_vec());
      end
    end
    step(1, 2, 0);
    tests++;
    if ({err_pulse, err_count} !== {1'b1, 2'd1}) begin
      fails++;
      $display("FAIL repeat: got e=%b c=%0d want e=1 c=1",
               err_pulse, err_count);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      lock_from(1);
      step(1, 3, 0);
    end
    tests++;
    if (err_count !== 2'd3) begin
      fails++;
      $display("FAIL saturate: got %0d want 3", err_count);
    end
    step(0, 0, 1);
    tests++;
    if (err_count !== 2'd0) begin
      fails++;
      $display("FAIL clear: got %0d want 0", err_count);
    end
    lock_from(1);
    step(1, 3, 1);
    tests++;
    if ({err_count, err_pulse} !== {2'd1, 1'b1}) begin
      fails++;
      $display("FAIL clear_and_err: got c=%0d e=%b want c=1 e=1",
               err_count, err_pulse);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    lock_from(1); step(1, 3, 0);
    lock_from(1); step(1, 3, 0);
    lock_from(1);
    tests++;
    if ({locked, err_count} !== {1'b1, 2'd2}) begin
      fails++;
      $display("FAIL async_pre: got l=%b c=%0d want l=1 c=2",
               locked, err_count);
    end
    @(posedge clk);
    #3;
    res = 0;
    #1;
    model_reset();
    tests++;
    if ({locked, err_count, expected} !== {1'b0, 2'd0, 3'd0}) begin
      fails++;
      $display("FAIL async_reset: got l=%b c=%0d x=%0d want 0 0 0",
               locked, err_count, expected);
    end
    @(negedge clk);
    res = 1;
    step(1, 5, 0);
    tests++;
    if ({locked, err_pulse, rst_seen, expected} !== {3'b000, 3'd6}) begin
      fails++;
      $display("FAIL async_capture: got l=%b e=%b r=%b x=%0d want 0 0 0 6",
               locked, err_pulse, rst_seen, expected);
    end
  endtask

  task automatic test_random();
    int c;
    int r;
    bit v;
    bit clr;
    do_reset();
    for (int i = 0; i < 500; i++) begin
      v   = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 24) == 0);
      r   = $urandom_range(0, 11);
      if (r < 9) c = (m_prev + 1) % MODV;
      else if (r == 9) c = 0;
      else c = $urandom_range(0, MODV - 1);
      step(v, c, clr);
      tests++;
      if (dut_vec() !== mdl_vec()) begin
        fails++;
        $display("FAIL random[%0d]: got %b want %b",
                 i, dut_vec(), mdl_vec());
      end
      tests++;
      if (err_pulse === 1'b1 && rst_seen === 1'b1) begin
        fails++;
        $display("FAIL both_pulses[%0d]: got 11 want not both", i);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_lock_wrap();
    test_skip();
    test_counter_reset();
    test_gaps();
    test_saturation();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
